dac_writer: RTL and testbench
=============================

# dac_writer

Serial DAC write engine: accepts a parallel sample stream over a valid/ready handshake and shifts each sample, prefixed by a fixed command field, to an SPI-style DAC (CS low, SCLK idles low, DAC captures DIN on SCLK rising edge). It is the transmit-side counterpart of the ADC sampler and sits between the sample-processing pipeline and the board DAC pins. It holds one sample in a single-entry buffer, so the next sample can be accepted while the current frame shifts.

## Interface
Parameters:
- DATA_WIDTH, 12, sample width in bits.
- CMD_BITS, 4, width of the command prefix.
- CMD, 4'b0011, command prefix value (write-and-update), sent MSB first ahead of the data.
- SCLK_DIV, 4, clk cycles per SCLK half period (must be ≥2).
- CS_GAP, 2, minimum clk cycles CS stays high between frames (must be ≥1).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  run enable; low aborts any frame and clears the buffer.
- sample_data  input  DATA_WIDTH  sample to write.
- sample_valid  input  1  sample_data valid.
- sample_ready  output  1  buffer can accept a sample.
- dac_sclk  output  1  serial clock, idles low.
- dac_cs_n  output  1  chip select, active low.
- dac_din  output  1  serial data, MSB first.
- busy  output  1  high while CS is low or in the CS gap.
- frame_done  output  1  one-cycle pulse on the cycle CS goes high after a complete frame.
- underrun  output  1  one-cycle pulse when the engine returns to IDLE with enable high and no buffered sample.

## Operation
- FRAME_BITS = CMD_BITS + DATA_WIDTH; shift word = {CMD, sample}.
- Buffer: sample_ready = enable && !buf_full (registered). A handshake (valid && ready) loads buf and sets buf_full.
- States: IDLE, SHIFT, GAP.
- IDLE: if enable && buf_full, load shift register, clear buf_full, set cs_n=0 and din=shift word MSB, reset divider, go to SHIFT. A new sample may be accepted one cycle later.
- SHIFT: divider counts 0..SCLK_DIV-1; at terminal count SCLK toggles. Each falling edge except the last shifts left and drives the next bit on din. After the FRAME_BITS-th falling edge: cs_n=1, din=0, frame_done=1, go to GAP.
- GAP: count CS_GAP cycles with cs_n high, then go to IDLE. If enable is high and buf_full is clear on entry to IDLE, pulse underrun.
- enable low, any state: same cycle cs_n=1, sclk=0, din=0, buf_full=0, state=IDLE, divider=0, no frame_done or underrun. A partial frame is intentionally discarded by the DAC because CS rises early.
- A handshake on the same cycle IDLE consumes the buffer is impossible because sample_ready is low while buf_full is set. A handshake during SHIFT or GAP is legal.

## Timing
- Reset values: cs_n=1, sclk=0, din=0, sample_ready=0, busy=0, frame_done=0, underrun=0, buf empty, state IDLE.
- Cycle t0 is when cs_n falls. The k-th SCLK rise is at t0 + (2k−1)·SCLK_DIV and the k-th fall at t0 + 2k·SCLK_DIV, for k = 1..FRAME_BITS.
- cs_n rises at t0 + 2·FRAME_BITS·SCLK_DIV, with frame_done on that cycle.
- din is stable at least SCLK_DIV cycles on each side of every rising edge.
- Earliest next cs_n fall is t0 + 2·FRAME_BITS·SCLK_DIV + CS_GAP + 1.
- Latency: handshake in IDLE at cycle c gives cs_n low at c+2 (buffer register, then IDLE launch).
- Sustained throughput is one sample per 2·FRAME_BITS·SCLK_DIV + CS_GAP + 1 cycles with no underrun, provided the next sample is accepted before GAP ends.

## Structure
- Shared package dac_pkg:
  - state encoding (IDLE/SHIFT/GAP);
  - standard command constants (write-and-update, write-only, power-down);
  - the FRAME_BITS function.
- Natural sub-module serial_clk_gen: divider plus SCLK toggle with rise/fall strobes and synchronous clear. It is reusable by the ADC side.
- Single-entry buffer and shift FSM live in dac_writer.

## Test plan
Defaults throughout: DATA_WIDTH=12, CMD=4'b0011, SCLK_DIV=4, CS_GAP=2.
- **Reset and idle:** assert rst mid-frame → next cycle cs_n=1, sclk=0, din=0, ready=0. Release with enable=1 → ready=1 one cycle later and no SCLK activity.
- **Single frame:** one handshake of 0xA5C → cs_n low 2 cycles later for exactly 128 cycles. The 16 bits sampled at SCLK rising edges equal 0x3A5C, frame_done pulses once, then underrun pulses after the gap.
- **Back-to-back:** valid held high with 0x000, 0xFFF, 0x800 → three frames with cs_n high exactly 3 cycles between them. Captured words are 0x3000, 0x3FFF, 0x3800, with no underrun until after the last.
- **Handshake timing:** during SHIFT, offer a sample → accepted (ready=1 then 0). A second offer → ready stays 0 until the next frame launches.
- **Abort:** drop enable at the 7th SCLK rise → cs_n=1 and sclk=0 the same cycle, buffer cleared, no frame_done. Re-enable with 0x123 → full 0x3123 frame.
- **Divider corner:** SCLK_DIV=2, CS_GAP=1 → frame length 64 cycles and SCLK period 4 cycles. Next frame starts no earlier than 2 cycles after cs_n rises.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC write engine: FSM encoding,
// standard command prefixes and the frame-length helper.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } dac_state_e;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_WRITE_ONLY   = 4'b0000;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

    function automatic int frame_bits(input int cmd_bits, input int data_width);
        return cmd_bits + data_width;
    endfunction

endpackage

// File: rtl/serial_clk_gen.sv
// Divided serial clock with strobes that flag the clk cycle on whose closing
// edge SCLK will rise or fall; shared by the DAC and ADC serial engines.
module serial_clk_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term = run && (cnt == TERM);
    assign rise = term && !sclk;
    assign fall = term && sclk;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (run) begin
            if (term) begin
                cnt  <= '0;
                sclk <= !sclk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_writer.sv
// Serial DAC write engine: single-entry sample buffer feeding a
// {command, sample} shifter that drives an SPI-style DAC, MSB first.
module dac_writer
    import dac_pkg::*;
#(
    parameter int                  DATA_WIDTH = 12,
    parameter int                  CMD_BITS   = 4,
    parameter logic [CMD_BITS-1:0] CMD        = CMD_WRITE_UPDATE,
    parameter int                  SCLK_DIV   = 4,
    parameter int                  CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  dac_sclk,
    output logic                  dac_cs_n,
    output logic                  dac_din,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun,
    output dac_state_e            dbg_state
);
    localparam int FB = frame_bits(CMD_BITS, DATA_WIDTH);
    localparam int BW = $clog2(FB + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [BW-1:0] BITS_DONE = BW'(FB);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    // Handshake: a sample transfers on a cycle where sample_valid && sample_ready.
    dac_state_e            state, state_next;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_full, buf_full_next;
    logic                  ready_q;
    logic [FB-1:0]         shreg;
    logic                  din_q, cs_n_q, done_q, under_q;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  hs, launch, last_fall, gap_end;
    logic                  sclk_q, sclk_rise, sclk_fall;

    serial_clk_gen #(.DIV(SCLK_DIV)) u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (!enable || launch),
        .run   (state == ST_SHIFT),
        .sclk  (sclk_q),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    assign hs = sample_valid && sample_ready;

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        last_fall  = 1'b0;
        gap_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    launch     = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The DAC has captured every bit once the rise count reaches FB.
                if (sclk_fall && bit_cnt == BITS_DONE) begin
                    last_fall  = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_end    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!enable) state_next = ST_IDLE;

        buf_full_next = buf_full;
        if (!enable)     buf_full_next = 1'b0;
        else if (hs)     buf_full_next = 1'b1;
        else if (launch) buf_full_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
            ready_q  <= 1'b0;
            shreg    <= '0;
            din_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state    <= state_next;
            buf_full <= buf_full_next;
            ready_q  <= !buf_full_next;
            done_q   <= last_fall;
            under_q  <= gap_end && !buf_full_next;

            if (launch) begin
                shreg   <= {CMD, buf_data};
                din_q   <= CMD[CMD_BITS-1];
                cs_n_q  <= 1'b0;
                bit_cnt <= '0;
            end else if (last_fall) begin
                cs_n_q <= 1'b1;
                din_q  <= 1'b0;
            end else if (state == ST_SHIFT) begin
                if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
                if (sclk_fall) begin
                    shreg <= shreg << 1;
                    din_q <= shreg[FB-2];
                end
            end

            if (state == ST_GAP && !gap_end) gap_cnt <= gap_cnt + 1'b1;
            else                             gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) buf_data <= sample_data;
    end

    // Dropping enable forces the pins idle in the same cycle so the DAC sees CS rise.
    assign sample_ready = ready_q && enable;
    assign dac_cs_n     = cs_n_q || !enable;
    assign dac_sclk     = sclk_q && enable;
    assign dac_din      = din_q && enable;
    assign busy         = enable && (state != ST_IDLE);
    assign frame_done   = done_q && enable;
    assign underrun     = under_q && enable;
    assign dbg_state    = state;

endmodule

// File: tb/tb_dac_writer.sv
// Bench for dac_writer: position-based output model checked every cycle,
// frame capture with a word scoreboard, and a fast-divider second instance.
module tb_dac_writer;
    import dac_pkg::*;

    localparam int DIV = 4;
    localparam int GAP = 2;
    localparam int FB  = 16;
    localparam int FL  = 2 * FB * DIV;
    localparam logic [3:0] CMD_V = 4'b0011;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic        sample_ready, dac_sclk, dac_cs_n, dac_din, busy, frame_done, underrun;
    dac_state_e  dbg_state;

    logic        enable2 = 1'b0, valid2 = 1'b0;
    logic [11:0] data2 = '0;
    logic        ready2, sclk2, cs2, din2, busy2, fd2, ur2;
    dac_state_e  dbg2;

    int checks = 0, failures = 0, cyc = 0;
    int fd_cnt = 0, ur_cnt = 0, fd2_cnt = 0, ur2_cnt = 0;
    logic [15:0] exp_q[$], got_q[$];
    int len_q[$], gap_q[$];

    dac_writer dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .dac_sclk(dac_sclk),
        .dac_cs_n(dac_cs_n), .dac_din(dac_din), .busy(busy), .frame_done(frame_done),
        .underrun(underrun), .dbg_state(dbg_state)
    );

    dac_writer #(.SCLK_DIV(2), .CS_GAP(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .sample_data(data2),
        .sample_valid(valid2), .sample_ready(ready2), .dac_sclk(sclk2),
        .dac_cs_n(cs2), .dac_din(din2), .busy(busy2), .frame_done(fd2),
        .underrun(ur2), .dbg_state(dbg2)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d, output int hs_cyc);
        int n;
        n = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        while (!sample_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", n < 2000, 1);
        hs_cyc = cyc;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_cs_fall();
        int n;
        n = 0;
        @(negedge clk);
        while (dac_cs_n !== 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("cs_fall_timeout", n < 1000, 1);
    endtask

    // model: frame position since CS fell, plus buffer and ready register
    initial begin
        int          m_pos;
        logic        m_full, m_rdy, e_rdy, e_cs, e_sclk, e_din, e_busy, e_fd, e_ur;
        logic        hs, idle, launch;
        logic [11:0] m_buf;
        logic [15:0] m_word;
        m_pos = -1; m_full = 1'b0; m_rdy = 1'b0; m_buf = '0; m_word = '0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            e_rdy = enable && m_rdy;
            e_cs = 1'b1; e_sclk = 1'b0; e_din = 1'b0; e_busy = 1'b0; e_fd = 1'b0; e_ur = 1'b0;
            if (enable) begin
                if (m_pos >= 0 && m_pos < FL) begin
                    e_cs   = 1'b0;
                    e_sclk = ((m_pos / DIV) % 2) == 1;
                    e_din  = m_word[FB - 1 - m_pos / (2 * DIV)];
                    e_busy = 1'b1;
                end else if (m_pos >= FL && m_pos < FL + GAP) begin
                    e_busy = 1'b1;
                    e_fd   = (m_pos == FL);
                end else begin
                    e_ur = (m_pos == FL + GAP) && !m_full;
                end
            end
            check("cs_n", dac_cs_n, e_cs);
            check("sclk", dac_sclk, e_sclk);
            check("din", dac_din, e_din);
            check("busy", busy, e_busy);
            check("frame_done", frame_done, e_fd);
            check("underrun", underrun, e_ur);
            check("ready", sample_ready, e_rdy);

            if (rst || !enable) begin
                m_pos = -1; m_full = 1'b0; m_rdy = 1'b0;
            end else begin
                hs     = sample_valid && e_rdy;
                idle   = (m_pos < 0) || (m_pos == FL + GAP);
                launch = idle && m_full;
                if (launch) begin
                    m_word = {CMD_V, m_buf};
                    m_pos  = 0;
                end else if (m_pos == FL + GAP) m_pos = -1;
                else if (m_pos >= 0)           m_pos++;
                if (hs) begin
                    m_full = 1'b1;
                    m_buf  = sample_data;
                end else if (launch) m_full = 1'b0;
                m_rdy = !m_full;
            end
        end
    end

    // frame capture: bits at SCLK rises, only complete frames are scored
    initial begin
        logic        ps, pc;
        logic [15:0] w;
        int          nb, t_fall, t_rise;
        ps = 1'b0; pc = 1'b1; w = '0; nb = 0; t_fall = 0; t_rise = -1;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (underrun) ur_cnt++;
            if (fd2) fd2_cnt++;
            if (ur2) ur2_cnt++;
            if (!dac_cs_n && pc) begin
                nb = 0; w = '0; t_fall = cyc;
                if (t_rise >= 0) gap_q.push_back(cyc - t_rise);
            end
            if (!dac_cs_n && dac_sclk && !ps) begin
                w = {w[14:0], dac_din};
                nb++;
            end
            if (dac_cs_n && !pc) begin
                t_rise = cyc;
                if (nb == FB) begin
                    got_q.push_back(w);
                    len_q.push_back(cyc - t_fall);
                end
            end
            ps = dac_sclk;
            pc = dac_cs_n;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int hc, n;
        logic [15:0] w2_exp[2];
        w2_exp[0] = 16'h3ABC;
        w2_exp[1] = 16'h30F0;

        repeat (3) tick();
        enable = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", dbg_state, ST_IDLE);
        check("ready_first_cycle", sample_ready, 0);
        check("reset_cs_n", dac_cs_n, 1);
        tick();
        @(negedge clk);
        check("ready_after_release", sample_ready, 1);
        repeat (5) tick();

        // single frame
        send(12'hA5C, hc);
        exp_q.push_back(16'h3A5C);
        wait_cs_fall();
        check("launch_latency", cyc - hc, 2);
        repeat (FL + 10) tick();
        check("single_len", len_q.size() > 0 ? len_q[0] : -1, 128);
        check("single_fd", fd_cnt, 1);
        check("single_ur", ur_cnt, 1);

        // back-to-back
        gap_q.delete();
        send(12'h000, hc); exp_q.push_back(16'h3000);
        send(12'hFFF, hc); exp_q.push_back(16'h3FFF);
        send(12'h800, hc); exp_q.push_back(16'h3800);
        repeat (2 * (FL + GAP + 1) + 10) tick();
        check("b2b_gap1", gap_q.size() > 1 ? gap_q[1] : -1, 3);
        check("b2b_gap2", gap_q.size() > 2 ? gap_q[2] : -1, 3);
        check("b2b_fd", fd_cnt, 4);
        check("b2b_ur", ur_cnt, 2);

        // handshake during SHIFT, second offer blocked
        send(12'h111, hc); exp_q.push_back(16'h3111);
        wait_cs_fall();
        repeat (10) tick();
        sample_valid = 1'b1;
        sample_data  = 12'h222;
        @(negedge clk);
        check("hs_shift_ready", sample_ready, 1);
        tick();
        sample_data = 12'h333;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (sample_ready) n++;
        end
        check("hs_blocked", n, 0);
        exp_q.push_back(16'h3222);
        send(12'h333, hc); exp_q.push_back(16'h3333);
        repeat (2 * (FL + GAP + 1) + 10) tick();
        check("hs_fd", fd_cnt, 7);
        check("hs_ur", ur_cnt, 3);

        // abort at the 7th SCLK rise with a sample buffered
        send(12'h456, hc);
        wait_cs_fall();
        tick();
        sample_valid = 1'b1;
        sample_data  = 12'h789;
        @(negedge clk);
        check("abort_buf_ready", sample_ready, 1);
        tick();
        sample_valid = 1'b0;
        repeat (50) tick();
        enable = 1'b0;
        @(negedge clk);
        check("abort_cs", dac_cs_n, 1);
        check("abort_sclk", dac_sclk, 0);
        repeat (3) tick();
        enable = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (!dac_cs_n) n++;
        end
        check("abort_buf_cleared", n, 0);
        check("abort_no_fd", fd_cnt, 7);
        tick();
        send(12'h123, hc); exp_q.push_back(16'h3123);
        repeat (FL + 10) tick();
        check("reenable_fd", fd_cnt, 8);
        check("reenable_ur", ur_cnt, 4);

        // reset mid-frame
        send(12'h5A5, hc);
        wait_cs_fall();
        repeat (30) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_cs", dac_cs_n, 1);
        check("rst_sclk", dac_sclk, 0);
        check("rst_din", dac_din, 0);
        check("rst_ready", sample_ready, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_release_ready", sample_ready, 1);

        // scoreboard
        check("word_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("frame_word", got_q.pop_front(), exp_q.pop_front());

        // divider corner: SCLK_DIV=2, CS_GAP=1
        enable2 = 1'b1;
        fork
            begin
                int k;
                valid2 = 1'b1;
                data2  = 12'hABC;
                for (int f = 0; f < 2; f++) begin
                    k = 0;
                    @(negedge clk);
                    while (!ready2 && k < 1000) begin
                        k++;
                        @(negedge clk);
                    end
                    check("div2_accept", k < 1000, 1);
                    tick();
                    data2 = 12'h0F0;
                end
                valid2 = 1'b0;
            end
            begin
                int m, len, r1, r2, nr, g;
                logic ps;
                logic [15:0] w;
                @(negedge clk);
                for (int f = 0; f < 2; f++) begin
                    m = 0;
                    while (cs2 !== 1'b0 && m < 500) begin
                        m++;
                        @(negedge clk);
                    end
                    len = 0; nr = 0; r1 = 0; r2 = 0; ps = 1'b0; w = '0;
                    while (cs2 === 1'b0 && len < 500) begin
                        if (sclk2 && !ps) begin
                            w = {w[14:0], din2};
                            nr++;
                            if (nr == 1) r1 = len;
                            if (nr == 2) r2 = len;
                        end
                        ps = sclk2;
                        len++;
                        @(negedge clk);
                    end
                    check("div2_len", len, 64);
                    check("div2_bits", nr, 16);
                    check("div2_period", r2 - r1, 4);
                    check("div2_word", w, w2_exp[f]);
                    if (f == 0) begin
                        g = 0;
                        while (cs2 === 1'b1 && g < 100) begin
                            g++;
                            @(negedge clk);
                        end
                        check("div2_gap", g, 2);
                    end
                end
            end
        join
        repeat (6) tick();
        check("div2_fd", fd2_cnt, 2);
        check("div2_ur", ur2_cnt, 1);
        check("div2_idle", dbg2, ST_IDLE);
        check("div2_busy", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
